// File: rtl/gemm_pkg.sv
// Shared definitions for the GLB stream loader: FSM encoding, lane width and lane slicing.
package gemm_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/glb_stream_loader_if.sv
// BRAM read port and GLB lane-FIFO write side seen by the stream loader.
interface glb_stream_loader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PE_SIZE    = 16,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]         mem_addr0_o;
  logic                          mem_ce0_o;
  logic                          mem_we0_o;
  logic [PE_SIZE*DATA_WIDTH-1:0] mem_q0_i;
  logic [PE_SIZE-1:0]            fifo_full_i;
  logic [PE_SIZE-1:0]            wren_o;
  logic [PE_SIZE*DATA_WIDTH-1:0] wdata_o;

  modport master (
    output mem_addr0_o, mem_ce0_o, mem_we0_o, wren_o, wdata_o,
    input  mem_q0_i, fifo_full_i
  );

  modport slave (
    input  mem_addr0_o, mem_ce0_o, mem_we0_o, wren_o, wdata_o,
    output mem_q0_i, fifo_full_i
  );
endinterface

// File: rtl/glb_skew_line.sv
// Per-lane {valid,data} delay line of fixed DEPTH, advancing on adv; bypass passes the input through.
module glb_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             bypass,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, adv, bypass};
    assign out_valid  = in_valid;
    assign out_data   = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // Only skewed traffic enters the stages, so a bypassed command never leaves stale valids behind.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else if (adv) begin
        vld[0] <= in_valid & ~bypass;
        dat[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign out_valid = bypass ? in_valid : vld[DEPTH-1];
    assign out_data  = bypass ? in_data  : dat[DEPTH-1];
  end

endmodule

// File: rtl/glb_stream_loader.sv
// Streams a run of BRAM words into the PE_SIZE GLB lane FIFOs with backpressure and optional skew.
module glb_stream_loader
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LANE_W,
  parameter int unsigned PE_SIZE    = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  skew_i,
  glb_stream_loader_if.master   bus,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WORD_W = PE_SIZE * DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  out_q;
  logic [LEN_WIDTH-1:0]  out_next;
  logic                  skew_q;
  logic                  rvalid_q;
  logic [1:0]            skid_cnt;
  logic [1:0]            occ;
  logic [WORD_W-1:0]     skid0;
  logic [WORD_W-1:0]     skid1;
  logic                  ready;
  logic                  skid_valid;
  logic                  pop;
  logic                  issue;
  logic [PE_SIZE-1:0]    lane_valid;

  assign ready      = ~|bus.fifo_full_i;
  assign skid_valid = (skid_cnt != 2'd0);
  assign pop        = ready & skid_valid;
  // Occupancy net of this cycle's pop keeps one word per cycle while ready holds.
  assign occ        = skid_cnt + {1'b0, rvalid_q} - {1'b0, pop};
  assign issue      = (state == ST_RUN) && !occ[1];

  assign bus.mem_ce0_o   = issue;
  assign bus.mem_addr0_o = addr_q;
  assign bus.mem_we0_o   = 1'b0;
  assign bus.wren_o      = {PE_SIZE{ready}} & lane_valid;

  // Words issued but not yet written on the deepest lane; zero means everything has drained.
  assign out_next = out_q + LEN_WIDTH'(issue) - LEN_WIDTH'(bus.wren_o[PE_SIZE-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      out_q  <= '0;
      skew_q <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      out_q  <= out_next;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr_q <= base_addr_i;
            rem_q  <= len_i;
            skew_q <= skew_i;
            if (len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_next == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      rvalid_q <= issue;
      unique case ({rvalid_q, pop})
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= bus.mem_q0_i;
          else                  skid1 <= bus.mem_q0_i;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= bus.mem_q0_i;
          end else begin
            skid0 <= skid1;
            skid1 <= bus.mem_q0_i;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    glb_skew_line #(
      .DEPTH(k),
      .WIDTH(DATA_WIDTH)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .adv      (ready),
      .bypass   (~skew_q),
      .in_valid (skid_valid),
      .in_data  (skid0[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_valid(lane_valid[k]),
      .out_data (bus.wdata_o[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_glb_stream_loader.sv
// Directed and randomized commands against a cycle-level reference of the loader's transfer rules.
module tb_glb_stream_loader;

  localparam int unsigned PE = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 10;
  localparam int unsigned MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          skew_i;
  logic          busy_o;
  logic          done_o;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned mem [MEMSZ];
  bit          ce_prev = 1'b0;
  int unsigned addr_prev = 0;

  glb_stream_loader_if #(.DATA_WIDTH(DW), .PE_SIZE(PE), .ADDR_WIDTH(AW)) bus ();

  glb_stream_loader #(
    .DATA_WIDTH(DW),
    .PE_SIZE   (PE),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .skew_i     (skew_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal cycle c pushed later by every stall cycle at or before the moment it would occur.
  function automatic int unsigned smap(input int unsigned c, input int unsigned lo, input int unsigned hi);
    int unsigned t = c;
    if (lo != 0)
      for (int unsigned s = lo; s <= hi; s++)
        if (s <= t) t++;
    return t;
  endfunction

  task automatic drive_bram();
    bus.mem_q0_i = ce_prev ? mem[addr_prev] : $urandom;
  endtask

  task automatic run_cmd(input int unsigned base, input int unsigned len, input bit skew,
                         input int unsigned lo, input int unsigned hi, input int unsigned lane,
                         input int unsigned dup_at);
    int unsigned rd_a[$];
    int unsigned rd_c[$];
    int unsigned wr_d[PE][$];
    int unsigned wr_c[PE][$];
    int unsigned dn_c[$];
    int unsigned ideal_done;
    int unsigned n_cyc;
    ideal_done = (len == 0) ? 1 : (skew ? 2 + len + PE : 3 + len);
    n_cyc = smap(ideal_done, lo, hi) + 4;
    start_i = 1'b1;
    base_addr_i = AW'(base);
    len_i = LW'(len);
    skew_i = skew;
    drive_bram();
    @(posedge clk); #1;
    for (int unsigned rel = 1; rel <= n_cyc; rel++) begin
      bus.fifo_full_i = (lo != 0 && rel >= lo && rel <= hi) ? PE'(1 << lane) : '0;
      drive_bram();
      if (rel == dup_at) begin
        start_i = 1'b1;
        base_addr_i = AW'(base + 77);
        len_i = LW'(3);
        skew_i = ~skew;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      if (rel == 1 && len > 0) chk("busy_first_cycle", busy_o, 1);
      ce_prev = bus.mem_ce0_o;
      addr_prev = bus.mem_addr0_o;
      if (bus.mem_ce0_o) begin
        rd_a.push_back(bus.mem_addr0_o);
        rd_c.push_back(rel);
      end
      for (int unsigned k = 0; k < PE; k++)
        if (bus.wren_o[k]) begin
          wr_d[k].push_back(bus.wdata_o[k*DW +: DW]);
          wr_c[k].push_back(rel);
        end
      if (done_o) dn_c.push_back(rel);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    bus.fifo_full_i = '0;

    chk($sformatf("rd_count b%0d", base), rd_a.size(), len);
    for (int unsigned i = 0; i < rd_a.size() && i < len; i++) begin
      chk($sformatf("rd_addr[%0d] b%0d", i, base), rd_a[i], (base + i) % MEMSZ);
      chk($sformatf("rd_cycle[%0d] b%0d", i, base), rd_c[i], smap(1 + i, lo, hi));
    end
    for (int unsigned k = 0; k < PE; k++) begin
      chk($sformatf("wr_count lane%0d b%0d", k, base), wr_d[k].size(), len);
      for (int unsigned i = 0; i < wr_d[k].size() && i < len; i++) begin
        chk($sformatf("wr_data lane%0d[%0d] b%0d", k, i, base), wr_d[k][i],
            (mem[(base + i) % MEMSZ] >> (DW * k)) & 32'hff);
        chk($sformatf("wr_cycle lane%0d[%0d] b%0d", k, i, base), wr_c[k][i],
            smap(3 + i + (skew ? k : 0), lo, hi));
      end
    end
    chk($sformatf("done_count b%0d", base), dn_c.size(), 1);
    if (dn_c.size() > 0) chk($sformatf("done_cycle b%0d", base), dn_c[0], smap(ideal_done, lo, hi));
  endtask

  initial begin
    int unsigned b, l, lo, hi, ln;
    bit sk;
    for (int unsigned i = 0; i < MEMSZ; i++) mem[i] = $urandom;
    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    len_i = '0;
    skew_i = 1'b0;
    bus.fifo_full_i = '0;
    bus.mem_q0_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mem_addr0", bus.mem_addr0_o, 0);
    chk("rst mem_ce0", bus.mem_ce0_o, 0);
    chk("rst mem_we0", bus.mem_we0_o, 0);
    chk("rst wren", bus.wren_o, 0);
    chk("rst wdata", bus.wdata_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(5, 4, 1'b0, 0, 0, 0, 0);
    run_cmd(5, 4, 1'b1, 0, 0, 0, 0);
    run_cmd(20, 8, 1'b0, 4, 6, 2, 0);
    run_cmd(MEMSZ - 2, 4, 1'b0, 0, 0, 0, 0);
    run_cmd(100, 0, 1'b0, 0, 0, 0, 0);
    run_cmd(30, 6, 1'b0, 0, 0, 0, 2);
    run_cmd(60, 5, 1'b1, 5, 6, 3, 0);

    // Reset in cycle 4 of a len=8 run.
    start_i = 1'b1;
    base_addr_i = AW'(200);
    len_i = LW'(8);
    skew_i = 1'b1;
    drive_bram();
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int unsigned rel = 1; rel <= 4; rel++) begin
      if (rel == 4) rst = 1'b1;
      drive_bram();
      @(negedge clk);
      ce_prev = bus.mem_ce0_o;
      addr_prev = bus.mem_addr0_o;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    ce_prev = 1'b0;
    drive_bram();
    @(negedge clk);
    chk("midrst mem_addr0", bus.mem_addr0_o, 0);
    chk("midrst mem_ce0", bus.mem_ce0_o, 0);
    chk("midrst wren", bus.wren_o, 0);
    chk("midrst wdata", bus.wdata_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    @(posedge clk); #1;
    drive_bram();
    @(negedge clk);
    chk("midrst idle ce0", bus.mem_ce0_o, 0);
    chk("midrst idle done", done_o, 0);
    @(posedge clk); #1;
    run_cmd(40, 5, 1'b1, 0, 0, 0, 0);

    for (int unsigned r = 0; r < 6; r++) begin
      b  = $urandom_range(MEMSZ - 1, 0);
      l  = $urandom_range(12, 1);
      sk = 1'($urandom_range(1, 0));
      ln = $urandom_range(PE - 1, 0);
      if ($urandom_range(1, 0) == 1) begin
        lo = $urandom_range(2 + l, 3);
        hi = lo + $urandom_range(3, 0);
      end else begin
        lo = 0;
        hi = 0;
      end
      run_cmd(b, l, sk, lo, hi, ln, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
